// File: rtl/fft_input_loader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fft_input_loader
//   Collects a 32-point complex frame from a valid/ready sample stream, stores
//   it in bit-reversed (butterfly) order, then kicks the FFT control unit with a
//   one-cycle start pulse and holds the frame stable until the FFT reports done.
//
// Ports
//   clk         in   system clock, all state on rising edge
//   rst_n       in   asynchronous active-low reset
//   in_valid    in   upstream sample valid
//   in_ready    out  loader accepts a sample this cycle (high only while filling)
//   in_sof      in   first sample of a frame (resyncs write index to 0)
//   in_re       in   sample real part (signed, stored bit-exact)
//   in_im       in   sample imaginary part (signed, stored bit-exact)
//   clear       in   synchronous flush of partial frame index and drop_err
//   fft_start   out  one-cycle pulse to the FFT control unit
//   fft_done    in   registered valid from the FFT control unit
//   frame_data  out  stored frame, slot k at [2*DATA_W*k +: 2*DATA_W] = {re,im}
//   drop_err    out  sticky: a sample was offered while in_ready was low
// -----------------------------------------------------------------------------
module fft_input_loader #(
   parameter int DATA_W = 16,
   parameter int N_PTS  = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_sof,
   input  logic [DATA_W-1:0]          in_re,
   input  logic [DATA_W-1:0]          in_im,
   input  logic                       clear,
   output logic                       fft_start,
   input  logic                       fft_done,
   output logic [2*DATA_W*N_PTS-1:0]  frame_data,
   output logic                       drop_err
);

   // state | meaning
   // FILL  | accepting samples, in_ready high
   // START | one cycle, fft_start high, frame frozen
   // BUSY  | FFT running, frame frozen, wait for rising edge of fft_done

   localparam int SLOT_W = 2 * DATA_W;

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      START = 2'd1,
      BUSY  = 2'd2
   } state_t;

   state_t                      r_state;
   logic [4:0]                  r_widx;
   logic                        r_fft_start;
   logic                        r_drop_err;
   logic                        r_done_d;
   logic [2*DATA_W*N_PTS-1:0]   r_frame;

   logic                        w_in_ready;
   logic [4:0]                  w_wr_idx;
   logic [4:0]                  w_slot;

   function automatic logic [4:0] bitrev5(input logic [4:0] v);
      return {v[0], v[1], v[2], v[3], v[4]};
   endfunction

   assign w_in_ready = (r_state == FILL);
   // A start-of-frame sample always lands at index 0, whatever the count says.
   assign w_wr_idx   = in_sof ? 5'd0 : r_widx;
   assign w_slot     = bitrev5(w_wr_idx);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= FILL;
         r_widx      <= 5'd0;
         r_fft_start <= 1'b0;
         r_drop_err  <= 1'b0;
         r_done_d    <= 1'b0;
         r_frame     <= '0;
      end else begin
         r_done_d    <= fft_done;
         r_fft_start <= 1'b0;

         if (clear)
            r_drop_err <= 1'b0;
         else if (in_valid && !w_in_ready)
            r_drop_err <= 1'b1;

         case (r_state)
            FILL: begin
               // clear beats a coincident sample: nothing is written
               if (clear) begin
                  r_widx <= 5'd0;
               end else if (in_valid) begin
                  r_frame[SLOT_W*w_slot +: SLOT_W] <= {in_re, in_im};
                  if (in_sof) begin
                     r_widx <= 5'd1;
                  end else if (r_widx == 5'd31) begin
                     r_widx      <= 5'd0;
                     r_state     <= START;
                     r_fft_start <= 1'b1;
                  end else begin
                     r_widx <= r_widx + 5'd1;
                  end
               end
            end
            START: r_state <= BUSY;
            BUSY: begin
               // edge, not level: a done still held from the previous run is ignored
               if (fft_done && !r_done_d)
                  r_state <= FILL;
            end
            default: r_state <= FILL;
         endcase
      end
   end

   assign in_ready   = w_in_ready;
   assign fft_start  = r_fft_start;
   assign drop_err   = r_drop_err;
   assign frame_data = r_frame;

endmodule

// File: tb/tb_fft_input_loader.sv
`timescale 1ns/1ps
module tb_fft_input_loader;

   localparam int DW = 16;
   localparam int NP = 32;
   localparam int SW = 2 * DW;
   localparam int FW = SW * NP;

   logic           clk      = 1'b0;
   logic           rst_n    = 1'b1;
   logic           in_valid = 1'b0;
   logic           in_sof   = 1'b0;
   logic [DW-1:0]  in_re    = '0;
   logic [DW-1:0]  in_im    = '0;
   logic           clear    = 1'b0;
   logic           fft_done = 1'b0;
   logic           in_ready;
   logic           fft_start;
   logic           drop_err;
   logic [FW-1:0]  frame_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   fft_input_loader #(.DATA_W(DW), .N_PTS(NP)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sof     (in_sof),
      .in_re      (in_re),
      .in_im      (in_im),
      .clear      (clear),
      .fft_start  (fft_start),
      .fft_done   (fft_done),
      .frame_data (frame_data),
      .drop_err   (drop_err)
   );

   // ---------------- reference model ----------------
   // phase: 0 collecting, 1 start pulse due, 2 waiting for FFT
   logic [SW-1:0] m_slot [NP];
   int            m_widx      = 0;
   int            m_phase     = 0;
   logic          m_drop      = 1'b0;
   logic          m_done_prev = 1'b0;
   longint        m_cyc       = 0;

   typedef struct {
      longint        cyc;
      logic [FW-1:0] frame;
   } exp_t;
   exp_t exp_q[$];

   function automatic int brev(input int w);
      int r = 0;
      for (int i = 0; i < 5; i++) r = r * 2 + ((w >> i) & 1);
      return r;
   endfunction

   function automatic logic [FW-1:0] pack_model();
      logic [FW-1:0] p;
      for (int k = 0; k < NP; k++) p[k*SW +: SW] = m_slot[k];
      return p;
   endfunction

   initial begin
      for (int k = 0; k < NP; k++) m_slot[k] = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_phase = 0; m_widx = 0; m_drop = 1'b0; m_done_prev = 1'b0;
            for (int k = 0; k < NP; k++) m_slot[k] = '0;
            exp_q.delete();
         end else begin
            int   wi;
            logic rdy;
            exp_t e;
            m_cyc++;
            rdy = (m_phase == 0);
            if (clear) m_drop = 1'b0;
            else if (in_valid && !rdy) m_drop = 1'b1;
            if (m_phase == 0) begin
               if (clear) m_widx = 0;
               else if (in_valid) begin
                  wi = in_sof ? 0 : m_widx;
                  m_slot[brev(wi)] = {in_re, in_im};
                  if (in_sof) m_widx = 1;
                  else if (wi == NP - 1) begin
                     m_widx = 0;
                     m_phase = 1;
                     e.cyc = m_cyc;
                     e.frame = pack_model();
                     exp_q.push_back(e);
                  end else m_widx = wi + 1;
               end
            end else if (m_phase == 1) begin
               m_phase = 2;
            end else if (fft_done && !m_done_prev) begin
               m_phase = 0;
            end
            m_done_prev = fft_done;
         end
      end
   end

   // ---------------- comparison helpers ----------------
   task automatic chk_bit(input string name, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%b expected=%b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_slot(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic chk_frame(input string name, input logic [FW-1:0] got, input logic [FW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         int bad = -1;
         for (int k = NP - 1; k >= 0; k--)
            if (got[k*SW +: SW] !== exp[k*SW +: SW]) bad = k;
         n_errors++;
         $display("FAIL %s: slot %0d got=%h expected=%h at %0t", name, bad,
                  got[bad*SW +: SW], exp[bad*SW +: SW], $time);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         chk_bit("in_ready", in_ready, m_phase == 0);
         chk_bit("drop_err", drop_err, m_drop);
         chk_frame("frame_data", frame_data, pack_model());
         if (exp_q.size() > 0 && exp_q[0].cyc <= m_cyc) begin
            e = exp_q.pop_front();
            chk_bit("fft_start_due", fft_start, 1'b1);
            chk_frame("sb_frame", frame_data, e.frame);
         end else begin
            chk_bit("fft_start_idle", fft_start, 1'b0);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic v, input logic s, input logic [DW-1:0] re,
                       input logic [DW-1:0] im, input logic clr, input logic dn);
      in_valid = v; in_sof = s; in_re = re; in_im = im; clear = clr; fft_done = dn;
      @(negedge clk);
   endtask

   task automatic send_rand(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
   endtask

   task automatic finish_fft();
      repeat (3) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   initial begin
      int lat;
      int bcnt;
      logic dn;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      chk_bit("reset in_ready", in_ready, 1'b1);
      chk_bit("reset drop_err", drop_err, 1'b0);
      chk_frame("reset frame", frame_data, '0);

      // ramp frame: re=w, im=-w
      for (int w = 0; w < NP; w++) begin
         if (w == NP - 1) chk_bit("ramp no early start", fft_start, 1'b0);
         step(1'b1, w == 0, 16'(w), 16'(-w), 1'b0, 1'b0);
      end
      chk_bit("ramp start", fft_start, 1'b1);
      chk_slot("ramp slot16", frame_data[16*SW +: SW], {16'h0001, 16'hFFFF});
      chk_slot("ramp slot31", frame_data[31*SW +: SW], {16'h001F, 16'hFFE1});
      chk_slot("ramp slot24", frame_data[24*SW +: SW], {16'h0003, 16'hFFFD});

      // samples offered while busy are refused and flagged
      repeat (10) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      chk_bit("busy in_ready", in_ready, 1'b0);
      chk_bit("busy drop_err", drop_err, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
      chk_bit("clear drop_err", drop_err, 1'b0);
      chk_bit("clear keeps busy", in_ready, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk_bit("done exit", in_ready, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // fft_done held high from before the run must not end it
      for (int w = 0; w < NP; w++)
         step(1'b1, w == 0, 16'($urandom), 16'($urandom), 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk_bit("held done no exit", in_ready, 1'b0);
      repeat (6) step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk_bit("low done no exit", in_ready, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
      chk_bit("rise exit", in_ready, 1'b1);
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

      // sof resync mid-frame
      for (int i = 0; i < 10; i++)
         step(1'b1, i == 0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      step(1'b1, 1'b1, 16'h7FFF, 16'h8001, 1'b0, 1'b0);
      chk_slot("sof slot0", frame_data[0 +: SW], {16'h7FFF, 16'h8001});
      step(1'b1, 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b0);
      chk_slot("after sof slot16", frame_data[16*SW +: SW], {16'h1234, 16'h5678});
      send_rand(29);
      chk_bit("sof no early start", fft_start, 1'b0);
      send_rand(1);
      chk_bit("sof start", fft_start, 1'b1);
      finish_fft();

      // clear on the 20th sample
      send_rand(19);
      step(1'b1, 1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      send_rand(31);
      chk_bit("clear no early start", fft_start, 1'b0);
      send_rand(1);
      chk_bit("clear start", fft_start, 1'b1);
      finish_fft();

      // reset in the middle of a run
      send_rand(NP);
      repeat (3) step(1'b1, 1'b0, 16'($urandom), 16'($urandom), 1'b0, 1'b0);
      chk_bit("pre-reset drop_err", drop_err, 1'b1);
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_bit("async rst in_ready", in_ready, 1'b1);
      chk_bit("async rst fft_start", fft_start, 1'b0);
      chk_bit("async rst drop_err", drop_err, 1'b0);
      chk_frame("async rst frame", frame_data, '0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 16'(i + 100), 16'(i + 200), 1'b0, 1'b0);
      chk_slot("post-rst slot8", frame_data[8*SW +: SW], {16'd102, 16'd202});

      // random traffic with an FFT that answers after a random latency
      bcnt = 0;
      lat = 1;
      repeat (3000) begin
         if (m_phase != 2) begin
            bcnt = 0;
            lat = $urandom_range(1, 8);
         end else bcnt++;
         dn = (m_phase == 2) && (bcnt >= lat);
         step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
              16'($urandom), 16'($urandom), $urandom_range(0, 59) == 0, dn);
      end
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      chk_int("scoreboard drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
